// File: rtl/bus_arbiter2_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter2_pkg -- shared bus definitions for the two-source bus arbiter.
//
// Holds the FSM state encoding, the default hold/turnaround limits, the
// counter width and the arbitration helper functions. The arbiter top and its
// counter sub-module both import this package.
// -----------------------------------------------------------------------------
package bus_arbiter2_pkg;

  // Default limits, overridable per instance through bus_arbiter2 parameters.
  localparam int unsigned DEF_MAX_HOLD = 4;  // legal range 1..15
  localparam int unsigned DEF_TURN     = 1;  // legal range 1..3

  // Width of the shared hold/turnaround counter; wide enough for MAX_HOLD=15.
  localparam int CNT_W = 4;

  // Bus width of each source's data path.
  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2,
    ST_TURN = 2'd3
  } arb_state_t;

  // Select the winning source for a non-zero request vector. A lone requester
  // always wins; under contention the source not granted most recently wins.
  // Returns 1'b1 for source 1, 1'b0 for source 0.
  function automatic logic pick_src(input logic [1:0] req, input logic last_src);
    if (req == 2'b11) begin
      return ~last_src;
    end
    return req[1];
  endfunction

  // Map a source index onto its grant state.
  function automatic arb_state_t gnt_state(input logic src);
    return src ? ST_GNT1 : ST_GNT0;
  endfunction

endpackage : bus_arbiter2_pkg

// File: rtl/bus_arbiter2_arb_cnt.sv
// -----------------------------------------------------------------------------
// arb_cnt -- 4-bit load/increment/saturate counter shared by the arbiter for
// both the grant hold count and the turnaround dead-cycle count.
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset, clears count to 0
//   load   in   set count to 1 (first cycle of a new grant or turnaround)
//   inc    in   add one, stopping at sat
//   sat    in   [CNT_W-1:0] saturation limit for the current phase
//   count  out  [CNT_W-1:0] current count
// -----------------------------------------------------------------------------
module arb_cnt
  import bus_arbiter2_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             inc,
  input  logic [CNT_W-1:0] sat,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(1);
    end else if (inc && (count < sat)) begin
      count <= count + 1'b1;
    end
  end

endmodule : arb_cnt

// File: rtl/bus_arbiter2.sv
// -----------------------------------------------------------------------------
// bus_arbiter2 -- two-source arbiter for a shared 4-bit bus.
//
// Grants one source at a time, limits a grant to MAX_HOLD consecutive cycles
// while the other source is waiting, and inserts TURN dead cycles (both
// enables low) between grants so the two tristate buffer stages never fight.
// en0/q0 and en1/q1 are meant to drive one external 4-bit tristate buffer
// each, both onto a common bus; all outputs are registered so the buffer
// controls are glitch-free.
//
// Parameters
//   MAX_HOLD  max consecutive grant cycles under contention (1..15)
//   TURN      dead cycles between grants (1..3)
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset
//   req    in   [1:0] req[i] high = source i wants the bus
//   d0     in   [3:0] source 0 data
//   d1     in   [3:0] source 1 data
//   en0    out  enable for source 0 buffer stage
//   en1    out  enable for source 1 buffer stage
//   q0     out  [3:0] registered source 0 data
//   q1     out  [3:0] registered source 1 data
//   grant  out  [1:0] one-hot owner, always {en1,en0}
//   busy   out  high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module bus_arbiter2
  import bus_arbiter2_pkg::*;
#(
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD,
  parameter int unsigned TURN     = DEF_TURN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  output logic              en0,
  output logic              en1,
  output logic [DATA_W-1:0] q0,
  output logic [DATA_W-1:0] q1,
  output logic [1:0]        grant,
  output logic              busy
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] TURN_LIM = CNT_W'(TURN);

  arb_state_t       state;
  arb_state_t       next_state;
  logic             last_src;   // 1 = source 1 was granted most recently
  logic [CNT_W-1:0] cnt;
  logic             cnt_load;
  logic             cnt_inc;
  logic [CNT_W-1:0] cnt_sat;

  // ---------------------------------------------------------------------------
  // Shared hold / turnaround counter. It restarts at 1 on every entry into a
  // grant or turnaround phase, so within a phase it reads "cycles spent here".
  // ---------------------------------------------------------------------------
  arb_cnt u_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .inc   (cnt_inc),
    .sat   (cnt_sat),
    .count (cnt)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (|req) begin
          next_state = gnt_state(pick_src(req, last_src));
        end
      end
      // Keep the grant while the owner still requests and either nobody else
      // is waiting or the owner has not yet used up its hold allowance.
      ST_GNT0: begin
        if (!(req[0] && (!req[1] || (cnt < HOLD_LIM)))) begin
          next_state = ST_TURN;
        end
      end
      ST_GNT1: begin
        if (!(req[1] && (!req[0] || (cnt < HOLD_LIM)))) begin
          next_state = ST_TURN;
        end
      end
      // cnt counts dead cycles already shown; the last one arbitrates afresh
      // on the current req, so a source that re-requested during the
      // turnaround is treated exactly like a new request.
      ST_TURN: begin
        if (cnt >= TURN_LIM) begin
          next_state = (|req) ? gnt_state(pick_src(req, last_src)) : ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counter control: restart on any phase change into a counted phase,
  // otherwise count up to the limit of the current phase.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_load = (next_state != state) && (next_state != ST_IDLE);
    cnt_inc  = (next_state == state) && (state != ST_IDLE);
    cnt_sat  = (state == ST_TURN) ? TURN_LIM : HOLD_LIM;
  end

  // ---------------------------------------------------------------------------
  // Registered outputs, decoded from next_state so they line up with the state
  // the FSM occupies after this edge. Reset drops the enables at the same edge
  // with no turnaround, since the bus is being reset as a whole.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      en0      <= 1'b0;
      en1      <= 1'b0;
      grant    <= 2'b00;
      busy     <= 1'b0;
      q0       <= '0;
      q1       <= '0;
      last_src <= 1'b1;  // source 0 has priority out of reset
    end else begin
      en0   <= (next_state == ST_GNT0);
      en1   <= (next_state == ST_GNT1);
      grant <= {next_state == ST_GNT1, next_state == ST_GNT0};
      busy  <= (next_state != ST_IDLE);
      if (next_state == ST_GNT0) begin
        q0       <= d0;
        last_src <= 1'b0;
      end
      if (next_state == ST_GNT1) begin
        q1       <= d1;
        last_src <= 1'b1;
      end
    end
  end

endmodule : bus_arbiter2
